// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared state encoding, layout defaults and address helper for the glyph scheduler
package fb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CLEAR = 3'd4
    } fb_state_t;

    localparam int FB_GLYPH_ROWS  = 16;
    localparam int FB_DIGIT_PITCH = 2;
    localparam int FB_ROW_STRIDE  = 40;

    // Byte offset of one glyph row of one slot, relative to the framebuffer base.
    function automatic logic [31:0] fb_addr(input int slot, input int row,
                                            input int pitch, input int stride);
        return 32'(slot * pitch + row * stride);
    endfunction

endpackage

// File: rtl/fb_rr_picker.sv
// rtl/fb_rr_picker.sv - combinational round-robin selector of the first dirty slot at or after a pointer
module fb_rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_dirty,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    always_comb begin
        int idx;
        idx     = 0;
        o_idx   = '0;
        o_valid = |i_dirty;
        // Walk from farthest to nearest so the nearest dirty slot wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (i_dirty[IW'(idx)]) o_idx = IW'(idx);
        end
    end

endmodule

// File: rtl/fb_glyph_scheduler.sv
// rtl/fb_glyph_scheduler.sv - blits changed digit glyphs from font ROM into framebuffer RAM
// Optional FB_BLIT_CLEAR_EN: zero the glyph band of the framebuffer after reset before scanning.
module fb_glyph_scheduler
    import fb_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int GLYPH_W     = 7,
    parameter int GLYPH_ROWS  = FB_GLYPH_ROWS,
    parameter int DIGIT_PITCH = FB_DIGIT_PITCH,
    parameter int ROW_STRIDE  = FB_ROW_STRIDE,
    parameter int BASE_ADDR   = 0,
    parameter int FB_AW       = 16,
    parameter int FA_W        = 11
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_DIGITS*GLYPH_W-1:0] digit_code,
    input  logic                          force_all,
    output logic [FA_W-1:0]               font_addr,
    input  logic [7:0]                    font_data,
    output logic                          fb_we,
    output logic [FB_AW-1:0]              fb_waddr,
    output logic [7:0]                    fb_wdata,
    output logic                          busy,
    output logic                          blit_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RW = (GLYPH_ROWS > 1) ? $clog2(GLYPH_ROWS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(GLYPH_ROWS - 1);

    fb_state_t              r_state, w_next;
    logic [GLYPH_W-1:0]     r_shadow [NUM_DIGITS];
    logic [GLYPH_W-1:0]     r_code;
    logic [GLYPH_W-1:0]     w_pick_code;
    logic [NUM_DIGITS-1:0]  r_forced;
    logic [NUM_DIGITS-1:0]  w_dirty;
    logic [NUM_DIGITS-1:0]  w_take;
    logic [IW-1:0]          r_ptr, r_slot, w_pick_idx;
    logic                   w_pick_valid;
    logic [RW-1:0]          r_row;
    logic                   r_fb_we, r_font_sel, r_blit_done, r_busy;
    logic [FB_AW-1:0]       r_fb_waddr;
    logic                   w_we_d, w_font_sel_d, w_done_d;
    logic [FB_AW-1:0]       w_waddr_d;
    logic                   w_clr_last;
    logic [31:0]            w_clr_addr;

`ifdef FB_BLIT_CLEAR_EN
    localparam int CLR_N = GLYPH_ROWS * ROW_STRIDE;
    localparam int CW    = (CLR_N > 1) ? $clog2(CLR_N) : 1;
    localparam fb_state_t RESET_STATE = ST_CLEAR;

    logic [CW-1:0] r_clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 r_clr_cnt <= '0;
        else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    assign w_clr_last = (r_clr_cnt == CW'(CLR_N - 1));
    assign w_clr_addr = 32'(r_clr_cnt);
`else
    localparam fb_state_t RESET_STATE = ST_SCAN;

    assign w_clr_last = 1'b0;
    assign w_clr_addr = 32'd0;
`endif

    // A slot is dirty while its input differs from what was last drawn, or a redraw was forced.
    always_comb begin
        w_dirty     = '0;
        w_pick_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_dirty[i] = r_forced[i] | force_all |
                         (digit_code[i*GLYPH_W +: GLYPH_W] != r_shadow[i]);
            if (IW'(i) == w_pick_idx) w_pick_code = digit_code[i*GLYPH_W +: GLYPH_W];
        end
    end

    fb_rr_picker #(
        .N  (NUM_DIGITS),
        .IW (IW)
    ) u_picker (
        .i_dirty (w_dirty),
        .i_ptr   (r_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_take = (r_state == ST_SCAN && w_pick_valid) ?
                    (NUM_DIGITS'(1) << w_pick_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RESET_STATE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|w_dirty) w_next = ST_SCAN;
            ST_SCAN:  w_next = w_pick_valid ? ST_FETCH : ST_IDLE;
            ST_FETCH: if (r_row == LAST_ROW) w_next = ST_DRAIN;
            // Skip the empty scan when nothing is waiting.
            ST_DRAIN: w_next = (|w_dirty) ? ST_SCAN : ST_IDLE;
            ST_CLEAR: if (w_clr_last) w_next = ST_SCAN;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_we_d       = 1'b0;
        w_font_sel_d = 1'b0;
        w_done_d     = 1'b0;
        w_waddr_d    = r_fb_waddr;
        font_addr    = '0;
        case (r_state)
            ST_FETCH: begin
                w_we_d       = 1'b1;
                w_font_sel_d = 1'b1;
                w_done_d     = (r_row == LAST_ROW);
                w_waddr_d    = FB_AW'(32'(BASE_ADDR) +
                                      fb_addr(int'(r_slot), int'(r_row), DIGIT_PITCH, ROW_STRIDE));
                font_addr    = FA_W'(32'(r_code) * 32'(GLYPH_ROWS) + 32'(r_row));
            end
            ST_CLEAR: begin
                w_we_d    = 1'b1;
                w_waddr_d = FB_AW'(32'(BASE_ADDR) + w_clr_addr);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_forced <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= '0;
            r_code   <= '0;
            r_slot   <= '0;
            r_row    <= '0;
            r_ptr    <= '0;
        end else begin
            r_forced <= (r_forced | {NUM_DIGITS{force_all}}) & ~w_take;
            case (r_state)
                ST_SCAN: if (w_pick_valid) begin
                    r_shadow[w_pick_idx] <= w_pick_code;
                    r_code               <= w_pick_code;
                    r_slot               <= w_pick_idx;
                    r_row                <= '0;
                end
                ST_FETCH: r_row <= r_row + 1'b1;
                ST_DRAIN: r_ptr <= (r_slot == IW'(NUM_DIGITS - 1)) ? '0 : r_slot + 1'b1;
                default: ;
            endcase
        end
    end

    // Write stage trails the fetch by one cycle so font_data lines up with its address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fb_we     <= 1'b0;
            r_font_sel  <= 1'b0;
            r_fb_waddr  <= '0;
            r_blit_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fb_we     <= w_we_d;
            r_font_sel  <= w_font_sel_d;
            r_fb_waddr  <= w_waddr_d;
            r_blit_done <= w_done_d;
            r_busy      <= (w_next != ST_IDLE);
        end
    end

    assign fb_we     = r_fb_we;
    assign fb_waddr  = r_fb_waddr;
    assign fb_wdata  = r_font_sel ? font_data : 8'h00;
    assign busy      = r_busy;
    assign blit_done = r_blit_done;

endmodule
